packet_scheduler: RTL and testbench
===================================

// Module: packet_scheduler
// PURPOSE
//  Upstream stage of the fan packet generator. Accepts one fan command (ID + command code)
//  per valid/ready handshake and latches it. Drives the generator's start/reset inputs and
//  its ID/command fields so that the packet is transmitted REPEATS times, separated by an
//  idle gap. Reports completion with a one-cycle done pulse. The generator has no done
//  output, so this block times each packet with its own down-counter.
// PARAMETERS
//  ID_WIDTH     4      width of the fan ID field
//  CMD_WIDTH    7      width of the command code field
//  PKT_CYCLES   71604  ref_clk cycles reserved per packet (13 offsets x 3 phases x 1836)
//  GAP_CYCLES   18360  ref_clk cycles of idle between repetitions (10 bit periods)
//  REPEATS      4      transmissions per accepted command; must be >= 1
//  TIMER_WIDTH  18     timer width; must satisfy 2^TIMER_WIDTH > max(PKT_CYCLES, GAP_CYCLES)
//  REP_WIDTH    4      repeat-counter width; must satisfy 2^REP_WIDTH > REPEATS
// PORTS
//  ref_clk    in   1          single clock; all logic on the rising edge
//  reset_n    in   1          asynchronous, active-low reset
//  cmd_valid  in   1          command request
//  cmd_id     in   ID_WIDTH   fan ID; sampled on handshake
//  cmd_code   in   CMD_WIDTH  command code; sampled on handshake
//  cmd_ready  out  1          high only in IDLE; handshake = cmd_valid & cmd_ready
//  abort      in   1          terminates any transfer in progress
//  pkt_id     out  ID_WIDTH   latched ID, to the generator
//  pkt_cmd    out  CMD_WIDTH  latched command, to the generator
//  pkt_start  out  1          one-cycle start pulse, to the generator's start input
//  pkt_reset  out  1          one-cycle pulse on abort, to the generator's reset input
//  tx_active  out  1          high whenever state != IDLE
//  done       out  1          one-cycle pulse after the final repetition completes
// BEHAVIOUR
//  Reset (reset_n low, asynchronous):
//   - state = IDLE; timer = 0; rep_cnt = 0.
//   - pkt_id = 0, pkt_cmd = 0, pkt_start = 0, pkt_reset = 0, done = 0, tx_active = 0.
//   - cmd_ready = 1 once reset_n is high again.
//  Every output except cmd_ready is registered. cmd_ready = (state == IDLE).
//  FSM states: IDLE, START, SEND, GAP.
//   IDLE: on handshake -> latch cmd_id/cmd_code into pkt_id/pkt_cmd; rep_cnt = REPEATS-1;
//         next state START. With cmd_valid low, stay in IDLE.
//   START: lasts 1 cycle. pkt_start = 1 during it. timer = PKT_CYCLES-1. Next state SEND.
//   SEND: decrement timer each cycle. At timer == 0:
//         - if rep_cnt != 0: rep_cnt -= 1, timer = GAP_CYCLES-1, next state GAP;
//         - else: done = 1 for the next cycle, next state IDLE.
//   GAP: decrement timer each cycle. At timer == 0, next state START.
//  Timing:
//   - Handshake on edge N -> pkt_start high in cycle N+1.
//   - Start-to-start period = 1 + PKT_CYCLES + GAP_CYCLES cycles.
//   - Last pkt_start to done = 1 + PKT_CYCLES cycles.
//   - pkt_start is never high for two consecutive cycles.
//  pkt_id/pkt_cmd hold stable from latch until the next accepted command.
//   - Changes on cmd_id/cmd_code while busy have no effect.
//  cmd_valid while busy: ignored. cmd_ready stays 0; the requester keeps cmd_valid high.
//  A new handshake is possible in the same cycle that done is high, because state is IDLE.
//  abort (any state other than IDLE):
//   - next state IDLE; pkt_reset = 1 for one cycle; timer and rep_cnt cleared.
//   - No done pulse. pkt_start is suppressed if abort coincides with START.
//  abort in IDLE:
//   - no pkt_reset pulse.
//   - abort and cmd_valid together in IDLE: abort wins, no handshake; cmd_ready still reads 1.
//  Counters never wrap; the parameter constraints above guarantee this. The bench asserts them.
// TESTING  (bench parameters: PKT_CYCLES=10, GAP_CYCLES=5, REPEATS=3)
//  1. Command id=4'hA, code=7'h17, held valid 1 cycle -> pkt_id=A, pkt_cmd=17;
//     pkt_start pulses at N+1, N+17, N+33; done pulses at N+44; cmd_ready returns to 1.
//  2. Second cmd_valid asserted during SEND of test 1 -> no handshake until IDLE;
//     then accepted in the done cycle; its first pkt_start occurs 1 cycle later.
//  3. abort asserted in the 2nd GAP -> pkt_reset one pulse; state IDLE next cycle;
//     no done; no further pkt_start.
//  4. abort and cmd_valid together in IDLE -> no latch, no pkt_start, no pkt_reset.
//  5. reset_n driven low mid-SEND, off-edge -> all outputs 0 immediately;
//     after release, cmd_ready=1 and no pkt_start without a new command.
//  6. REPEATS=1 -> exactly one pkt_start; done exactly 11 cycles after it; no GAP state visited.

Source files
------------

// File: rtl/packet_scheduler.sv
// Fan packet scheduler: accepts one fan command, then starts the packet generator
// REPEATS times with an idle gap between packets, and pulses done after the last one.
module packet_scheduler #(
    parameter int ID_WIDTH    = 4,
    parameter int CMD_WIDTH   = 7,
    parameter int PKT_CYCLES  = 71604,
    parameter int GAP_CYCLES  = 18360,
    parameter int REPEATS     = 4,
    parameter int TIMER_WIDTH = 18,
    parameter int REP_WIDTH   = 4
) (
    input  logic                 ref_clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    input  logic [ID_WIDTH-1:0]  cmd_id,
    input  logic [CMD_WIDTH-1:0] cmd_code,
    output logic                 cmd_ready,
    input  logic                 abort,
    output logic [ID_WIDTH-1:0]  pkt_id,
    output logic [CMD_WIDTH-1:0] pkt_cmd,
    output logic                 pkt_start,
    output logic                 pkt_reset,
    output logic                 tx_active,
    output logic                 done,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [TIMER_WIDTH-1:0] PKT_LOAD  = TIMER_WIDTH'(PKT_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] GAP_LOAD  = TIMER_WIDTH'(GAP_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE = TIMER_WIDTH'(1);
    localparam logic [REP_WIDTH-1:0]   REP_LOAD  = REP_WIDTH'(REPEATS - 1);
    localparam logic [REP_WIDTH-1:0]   REP_ONE   = REP_WIDTH'(1);

    state_t                 state;
    logic [TIMER_WIDTH-1:0] timer;
    logic [REP_WIDTH-1:0]   rep_cnt;

    // Handshake: a command is taken on a rising edge where cmd_valid and cmd_ready are
    // both high and abort is low. cmd_ready depends only on state, never on cmd_valid,
    // so a requester may hold cmd_valid high across a busy period without side effects.
    assign cmd_ready = (state == IDLE);
    assign fsm_state = state;

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            timer     <= '0;
            rep_cnt   <= '0;
            pkt_id    <= '0;
            pkt_cmd   <= '0;
            pkt_start <= 1'b0;
            pkt_reset <= 1'b0;
            tx_active <= 1'b0;
            done      <= 1'b0;
        end else begin
            pkt_start <= 1'b0;
            pkt_reset <= 1'b0;
            done      <= 1'b0;
            if (abort && state != IDLE) begin
                // Abort also wins over a GAP->START transition, so no start pulse leaks out.
                state     <= IDLE;
                timer     <= '0;
                rep_cnt   <= '0;
                pkt_reset <= 1'b1;
                tx_active <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_valid && !abort) begin
                            pkt_id    <= cmd_id;
                            pkt_cmd   <= cmd_code;
                            rep_cnt   <= REP_LOAD;
                            state     <= START;
                            pkt_start <= 1'b1;
                            tx_active <= 1'b1;
                        end
                    end
                    START: begin
                        timer <= PKT_LOAD;
                        state <= SEND;
                    end
                    SEND: begin
                        if (timer == '0) begin
                            if (rep_cnt != '0) begin
                                rep_cnt <= rep_cnt - REP_ONE;
                                timer   <= GAP_LOAD;
                                state   <= GAP;
                            end else begin
                                done      <= 1'b1;
                                tx_active <= 1'b0;
                                state     <= IDLE;
                            end
                        end else begin
                            timer <= timer - TIMER_ONE;
                        end
                    end
                    GAP: begin
                        if (timer == '0) begin
                            pkt_start <= 1'b1;
                            state     <= START;
                        end else begin
                            timer <= timer - TIMER_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_packet_scheduler.sv
// Bench for packet_scheduler: a REPEATS=3 instance for the main scenarios and a
// REPEATS=1 instance for the single-shot case; event cycles are scored against queues.
module tb_packet_scheduler;

    localparam int ID_WIDTH    = 4;
    localparam int CMD_WIDTH   = 7;
    localparam int PKT_CYCLES  = 10;
    localparam int GAP_CYCLES  = 5;
    localparam int REPEATS     = 3;
    localparam int TIMER_WIDTH = 18;
    localparam int REP_WIDTH   = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GAP  = 2'd3;

    logic ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    logic reset_n;
    logic cmd_valid, cmd_ready, abort, pkt_start, pkt_reset, tx_active, done;
    logic [ID_WIDTH-1:0]  cmd_id, pkt_id;
    logic [CMD_WIDTH-1:0] cmd_code, pkt_cmd;
    logic [1:0] fsm_state;

    logic cmd_valid1, cmd_ready1, abort1, pkt_start1, pkt_reset1, tx_active1, done1;
    logic [ID_WIDTH-1:0]  cmd_id1, pkt_id1;
    logic [CMD_WIDTH-1:0] cmd_code1, pkt_cmd1;
    logic [1:0] fsm_state1;

    packet_scheduler #(
        .ID_WIDTH(ID_WIDTH), .CMD_WIDTH(CMD_WIDTH), .PKT_CYCLES(PKT_CYCLES),
        .GAP_CYCLES(GAP_CYCLES), .REPEATS(REPEATS), .TIMER_WIDTH(TIMER_WIDTH),
        .REP_WIDTH(REP_WIDTH)
    ) dut (
        .ref_clk(ref_clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_id(cmd_id),
        .cmd_code(cmd_code), .cmd_ready(cmd_ready), .abort(abort), .pkt_id(pkt_id),
        .pkt_cmd(pkt_cmd), .pkt_start(pkt_start), .pkt_reset(pkt_reset),
        .tx_active(tx_active), .done(done), .fsm_state(fsm_state)
    );

    packet_scheduler #(
        .ID_WIDTH(ID_WIDTH), .CMD_WIDTH(CMD_WIDTH), .PKT_CYCLES(PKT_CYCLES),
        .GAP_CYCLES(GAP_CYCLES), .REPEATS(1), .TIMER_WIDTH(TIMER_WIDTH),
        .REP_WIDTH(REP_WIDTH)
    ) dut1 (
        .ref_clk(ref_clk), .reset_n(reset_n), .cmd_valid(cmd_valid1), .cmd_id(cmd_id1),
        .cmd_code(cmd_code1), .cmd_ready(cmd_ready1), .abort(abort1), .pkt_id(pkt_id1),
        .pkt_cmd(pkt_cmd1), .pkt_start(pkt_start1), .pkt_reset(pkt_reset1),
        .tx_active(tx_active1), .done(done1), .fsm_state(fsm_state1)
    );

    initial begin
        assert ((1 << TIMER_WIDTH) > PKT_CYCLES && (1 << TIMER_WIDTH) > GAP_CYCLES);
        assert ((1 << REP_WIDTH) > REPEATS && REPEATS >= 1);
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] cyc = '0;
    always @(posedge ref_clk) cyc <= cyc + 1;

    // Event cycle index = number of rising edges before the cycle in which it is high.
    logic [31:0] exp_start_q[$], obs_start_q[$], exp_done_q[$], obs_done_q[$];
    logic [31:0] exp_reset_q[$], obs_reset_q[$];
    logic [31:0] exp_start1_q[$], obs_start1_q[$], exp_done1_q[$], obs_done1_q[$];
    bit   saw_gap1 = 0;
    bit   saw_double = 0;
    logic prev_start = 1'b0;
    logic [31:0] t2_base;

    always @(negedge ref_clk) begin
        if (pkt_start)  obs_start_q.push_back(cyc + 1);
        if (done)       obs_done_q.push_back(cyc + 1);
        if (pkt_reset)  obs_reset_q.push_back(cyc + 1);
        if (pkt_start1) obs_start1_q.push_back(cyc + 1);
        if (done1)      obs_done1_q.push_back(cyc + 1);
        if (fsm_state1 == ST_GAP) saw_gap1 = 1;
        if (pkt_start && prev_start) saw_double = 1;
        prev_start = pkt_start;
    end

    task automatic do_handshake(input bit sel, input logic [ID_WIDTH-1:0] id,
                                input logic [CMD_WIDTH-1:0] code, output logic [31:0] hs_cyc);
        bit rdy;
        bit got;
        got = 0;
        @(negedge ref_clk);
        if (sel) begin cmd_valid1 = 1; cmd_id1 = id; cmd_code1 = code; end
        else     begin cmd_valid  = 1; cmd_id  = id; cmd_code  = code; end
        for (int i = 0; i < 200 && !got; i++) begin
            rdy = sel ? cmd_ready1 : cmd_ready;
            @(posedge ref_clk); #1;
            if (rdy) got = 1;
            else @(negedge ref_clk);
        end
        hs_cyc = cyc;
        if (sel) cmd_valid1 = 0; else cmd_valid = 0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: got none, required one within 200 cycles");
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (3) @(posedge ref_clk);
        #1;
        checks++;
        if ({pkt_id, pkt_cmd, pkt_start, pkt_reset, done, tx_active} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: id=%h cmd=%h st=%b rs=%b dn=%b act=%b, required all 0",
                     pkt_id, pkt_cmd, pkt_start, pkt_reset, done, tx_active);
        end
        @(negedge ref_clk);
        reset_n = 1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || cmd_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b, required 1/1", cmd_ready, cmd_ready1);
        end
    endtask

    task automatic test_basic();
        logic [31:0] n, e, o;
        bit seen;
        do_handshake(0, 4'hA, 7'h17, n);
        exp_start_q.push_back(n + 1);
        exp_start_q.push_back(n + 17);
        exp_start_q.push_back(n + 33);
        exp_done_q.push_back(n + 44);
        checks++;
        if (cmd_ready !== 1'b0 || tx_active !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: ready=%b active=%b, required 0/1", cmd_ready, tx_active);
        end
        checks++;
        if (pkt_id !== 4'hA || pkt_cmd !== 7'h17) begin
            errors++;
            $display("FAIL basic_latch: id=%h cmd=%h, required a/17", pkt_id, pkt_cmd);
        end
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge ref_clk);
            if (obs_done_q.size() > 0) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL basic_done_timeout: no done, required one by cycle %0d", n + 44);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready_after: got %b, required 1", cmd_ready);
        end
        while (exp_start_q.size() > 0) begin
            e = exp_start_q.pop_front();
            o = (obs_start_q.size() > 0) ? obs_start_q.pop_front() : 32'hFFFF_FFFF;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL basic_start_cycle: got %0d, required %0d", o, e);
            end
        end
        e = exp_done_q.pop_front();
        o = (obs_done_q.size() > 0) ? obs_done_q.pop_front() : 32'hFFFF_FFFF;
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL basic_done_cycle: got %0d, required %0d", o, e);
        end
        checks++;
        if (obs_start_q.size() != 0 || obs_done_q.size() != 0) begin
            errors++;
            $display("FAIL basic_extra_events: got %0d starts %0d dones, required 0 0",
                     obs_start_q.size(), obs_done_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] n, m, e, o;
        bit seen;
        do_handshake(0, 4'h3, 7'h22, n);
        t2_base = n;
        exp_start_q.push_back(n + 1);
        exp_start_q.push_back(n + 17);
        exp_start_q.push_back(n + 33);
        exp_start_q.push_back(n + 45);
        exp_done_q.push_back(n + 44);
        repeat (5) @(negedge ref_clk);
        cmd_valid = 1; cmd_id = 4'h5; cmd_code = 7'h55;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_busy: got %b, required 0", cmd_ready);
        end
        @(posedge ref_clk); #1;
        checks++;
        if (pkt_id !== 4'h3 || pkt_cmd !== 7'h22) begin
            errors++;
            $display("FAIL b2b_no_relatch: id=%h cmd=%h, required 3/22", pkt_id, pkt_cmd);
        end
        do_handshake(0, 4'h5, 7'h55, m);
        checks++;
        if (m !== n + 44) begin
            errors++;
            $display("FAIL b2b_accept_cycle: got %0d, required %0d", m, n + 44);
        end
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge ref_clk);
            if (obs_start_q.size() >= 4) seen = 1;
        end
        while (exp_start_q.size() > 0) begin
            e = exp_start_q.pop_front();
            o = (obs_start_q.size() > 0) ? obs_start_q.pop_front() : 32'hFFFF_FFFF;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_start_cycle: got %0d, required %0d", o, e);
            end
        end
        e = exp_done_q.pop_front();
        o = (obs_done_q.size() > 0) ? obs_done_q.pop_front() : 32'hFFFF_FFFF;
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL b2b_done_cycle: got %0d, required %0d", o, e);
        end
        checks++;
        if (pkt_id !== 4'h5 || pkt_cmd !== 7'h55) begin
            errors++;
            $display("FAIL b2b_latch2: id=%h cmd=%h, required 5/55", pkt_id, pkt_cmd);
        end
    endtask

    task automatic test_abort_gap();
        logic [31:0] ed, e, o;
        bit seen;
        exp_start_q.push_back(t2_base + 61);
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge ref_clk);
            if (obs_start_q.size() >= 1 && fsm_state == ST_GAP) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort_gap_timeout: second gap not reached, required within 60 cycles");
        end
        abort = 1;
        @(posedge ref_clk); #1;
        ed = cyc;
        abort = 0;
        exp_reset_q.push_back(ed + 1);
        checks++;
        if (fsm_state !== ST_IDLE || pkt_reset !== 1'b1 || tx_active !== 1'b0) begin
            errors++;
            $display("FAIL abort_effect: state=%0d rst=%b act=%b, required 0/1/0",
                     fsm_state, pkt_reset, tx_active);
        end
        repeat (40) @(negedge ref_clk);
        e = exp_start_q.pop_front();
        o = (obs_start_q.size() > 0) ? obs_start_q.pop_front() : 32'hFFFF_FFFF;
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL abort_prior_start: got %0d, required %0d", o, e);
        end
        checks++;
        if (obs_start_q.size() != 0 || obs_done_q.size() != 0) begin
            errors++;
            $display("FAIL abort_no_more: got %0d starts %0d dones, required 0 0",
                     obs_start_q.size(), obs_done_q.size());
        end
        e = exp_reset_q.pop_front();
        o = (obs_reset_q.size() > 0) ? obs_reset_q.pop_front() : 32'hFFFF_FFFF;
        checks++;
        if (o !== e || obs_reset_q.size() != 0) begin
            errors++;
            $display("FAIL abort_reset_pulse: got cycle %0d (+%0d more), required %0d once",
                     o, obs_reset_q.size(), e);
        end
    endtask

    task automatic test_abort_idle();
        @(negedge ref_clk);
        abort = 1; cmd_valid = 1; cmd_id = 4'h9; cmd_code = 7'h11;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_abort_ready: got %b, required 1", cmd_ready);
        end
        @(posedge ref_clk); #1;
        abort = 0; cmd_valid = 0;
        checks++;
        if (pkt_id !== 4'h5 || pkt_cmd !== 7'h55 || fsm_state !== ST_IDLE) begin
            errors++;
            $display("FAIL idle_abort_nolatch: id=%h cmd=%h state=%0d, required 5/55/0",
                     pkt_id, pkt_cmd, fsm_state);
        end
        repeat (20) @(negedge ref_clk);
        checks++;
        if (obs_start_q.size() != 0 || obs_reset_q.size() != 0) begin
            errors++;
            $display("FAIL idle_abort_events: got %0d starts %0d resets, required 0 0",
                     obs_start_q.size(), obs_reset_q.size());
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] n, o;
        do_handshake(0, 4'h6, 7'h66, n);
        exp_start_q.push_back(n + 1);
        repeat (6) @(negedge ref_clk);
        o = (obs_start_q.size() > 0) ? obs_start_q.pop_front() : 32'hFFFF_FFFF;
        checks++;
        if (o !== exp_start_q.pop_front()) begin
            errors++;
            $display("FAIL rst_pre_start: got %0d, required %0d", o, n + 1);
        end
        #2 reset_n = 0;
        #1;
        checks++;
        if ({pkt_id, pkt_cmd, pkt_start, pkt_reset, done, tx_active} !== '0
            || fsm_state !== ST_IDLE) begin
            errors++;
            $display("FAIL rst_async: id=%h cmd=%h act=%b state=%0d, required all 0",
                     pkt_id, pkt_cmd, tx_active, fsm_state);
        end
        @(negedge ref_clk);
        reset_n = 1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready: got %b, required 1", cmd_ready);
        end
        repeat (30) @(negedge ref_clk);
        checks++;
        if (obs_start_q.size() != 0 || obs_done_q.size() != 0) begin
            errors++;
            $display("FAIL rst_quiet: got %0d starts %0d dones, required 0 0",
                     obs_start_q.size(), obs_done_q.size());
        end
    endtask

    task automatic test_single_repeat();
        logic [31:0] n, e, o;
        bit seen;
        do_handshake(1, 4'hC, 7'h3C, n);
        exp_start1_q.push_back(n + 1);
        exp_done1_q.push_back(n + 12);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge ref_clk);
            if (obs_done1_q.size() > 0) seen = 1;
        end
        repeat (20) @(negedge ref_clk);
        e = exp_start1_q.pop_front();
        o = (obs_start1_q.size() > 0) ? obs_start1_q.pop_front() : 32'hFFFF_FFFF;
        checks++;
        if (o !== e || obs_start1_q.size() != 0) begin
            errors++;
            $display("FAIL single_start: got %0d (+%0d more), required %0d once",
                     o, obs_start1_q.size(), e);
        end
        e = exp_done1_q.pop_front();
        o = (obs_done1_q.size() > 0) ? obs_done1_q.pop_front() : 32'hFFFF_FFFF;
        checks++;
        if (o !== e || obs_done1_q.size() != 0) begin
            errors++;
            $display("FAIL single_done: got %0d (+%0d more), required %0d once",
                     o, obs_done1_q.size(), e);
        end
        checks++;
        if (saw_gap1 !== 1'b0) begin
            errors++;
            $display("FAIL single_no_gap: gap visited=%b, required 0", saw_gap1);
        end
        checks++;
        if (pkt_id1 !== 4'hC || pkt_cmd1 !== 7'h3C) begin
            errors++;
            $display("FAIL single_latch: id=%h cmd=%h, required c/3c", pkt_id1, pkt_cmd1);
        end
    endtask

    initial begin
        cmd_valid = 0; cmd_id = '0; cmd_code = '0; abort = 0;
        cmd_valid1 = 0; cmd_id1 = '0; cmd_code1 = '0; abort1 = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort_gap();
        test_abort_idle();
        test_async_reset();
        test_single_repeat();
        checks++;
        if (saw_double !== 1'b0) begin
            errors++;
            $display("FAIL start_consecutive: double pulse seen=%b, required 0", saw_double);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
